// File: rtl/cordic_mag_scale_if.sv
// Ready/valid bundle between the CORDIC vectoring pipeline, the magnitude
// scaler and its consumer.
//   in_valid   : sample entered the pipeline's x_i/y_i this cycle
//   mag_i      : pipeline x_o, signed, unscaled magnitude
//   out_valid  : buffer head valid
//   out_ready  : consumer accepts head when out_valid & out_ready
//   mag_o      : scaled magnitude, signed, always >= 0
//   overflow   : sticky "a sample was dropped" flag
//   drop_cnt   : saturating count of dropped samples
// master = producer/consumer side, slave = cordic_mag_scale.
interface cordic_mag_scale_if #(
  parameter int XY_BITS = 16
);
  logic                  in_valid;
  logic signed [XY_BITS:0] mag_i;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [XY_BITS:0] mag_o;
  logic                  overflow;
  logic [7:0]            drop_cnt;

  modport master (
    output in_valid, mag_i, out_ready,
    input  out_valid, mag_o, overflow, drop_cnt
  );

  modport slave (
    input  in_valid, mag_i, out_ready,
    output out_valid, mag_o, overflow, drop_cnt
  );
endinterface

// File: rtl/cordic_mag_scale.sv
// Downstream companion of the stall-free CORDIC vectoring pipeline.
// Tracks sample validity alongside the pipeline, removes the CORDIC gain
// (mag * 1/K) and presents results through a 2-entry ready/valid buffer.
// Samples that arrive while the buffer is full and not being read are
// dropped and counted.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : cordic_mag_scale_if.slave (in_valid, mag_i, out_ready in;
//          out_valid, mag_o, overflow, drop_cnt out)
// Parameters:
//   XY_BITS : magnitude is XY_BITS+1 bits signed
//   LATENCY : pipeline depth from x_i/y_i to x_o (>= 2)
//   KINV    : 1/K in unsigned Q0.16
// Build option:
//   CORDIC_SCALE_ROUND_EN : round half up instead of truncating the product.
module cordic_mag_scale #(
  parameter int          XY_BITS = 16,
  parameter int          LATENCY = 15,
  parameter int unsigned KINV    = 39797
) (
  input logic               clk,
  input logic               rst,
  cordic_mag_scale_if.slave bus
);

  localparam int PW = 2 * (XY_BITS + 1);

  // Validity delay line matching the pipeline depth
  logic [LATENCY-1:0] vd_q, vd_d;

  // Scale stage
  logic [XY_BITS-1:0] op;
  logic [PW-1:0]      prod, prod_r;
  logic [XY_BITS:0]   p_mag_q, p_mag_d;
  logic               p_val_q, p_val_d;

  // 2-entry buffer
  logic [XY_BITS:0]   mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         cnt_q, cnt_d;
  logic               rd, wr, full, drop;

  logic               overflow_q, overflow_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  always_comb begin
    vd_d = {vd_q[LATENCY-2:0], bus.in_valid};
  end

  always_comb begin
    // A negative x_o means the pipeline wrapped; treat it as zero magnitude
    op      = bus.mag_i[XY_BITS] ? '0 : bus.mag_i[XY_BITS-1:0];
    prod    = PW'(op) * PW'(KINV);
`ifdef CORDIC_SCALE_ROUND_EN
    prod_r  = prod + PW'(32768);
`else
    prod_r  = prod;
`endif
    // Result is below 2^XY_BITS, so the top bit of the slice is always 0
    p_mag_d = prod_r[16 +: XY_BITS+1];
    p_val_d = vd_q[LATENCY-1];
  end

  always_comb begin
    full       = (cnt_q == 2'd2);
    rd         = (cnt_q != 2'd0) && bus.out_ready;
    // A full buffer still accepts a write when the head leaves this cycle
    wr         = p_val_q && (!full || rd);
    drop       = p_val_q && full && !rd;
    cnt_d      = cnt_q;
    if (wr && !rd)      cnt_d = cnt_q + 2'd1;
    else if (!wr && rd) cnt_d = cnt_q - 2'd1;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vd_q       <= '0;
      p_val_q    <= 1'b0;
      p_mag_q    <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      vd_q       <= vd_d;
      p_val_q    <= p_val_d;
      p_mag_q    <= p_mag_d;
      if (wr) mem_q[wr_ptr_q] <= p_mag_q;
      wr_ptr_q   <= wr_ptr_q ^ wr;
      rd_ptr_q   <= rd_ptr_q ^ rd;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    bus.out_valid = (cnt_q != 2'd0);
    bus.mag_o     = mem_q[rd_ptr_q];
    bus.overflow  = overflow_q;
    bus.drop_cnt  = drop_cnt_q;
  end

endmodule
